// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared encodings for the LSU: access-size masks, fault codes, FSM states
// and the misalignment predicate used by YSYX_25040111_MISALIGN_CHK_EN.
package ysyx_25040111_lsu_pkg;

    localparam logic [1:0] MASK_B = 2'b01;
    localparam logic [1:0] MASK_H = 2'b10;
    localparam logic [1:0] MASK_W = 2'b11;

    localparam logic [3:0] ERR_LD_MISALIGN = 4'd4;
    localparam logic [3:0] ERR_LD_FAULT    = 4'd5;
    localparam logic [3:0] ERR_ST_MISALIGN = 4'd6;
    localparam logic [3:0] ERR_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] a);
        is_misaligned = ((mask == MASK_H) && a[0]) || ((mask == MASK_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Lane logic: store strobes and replicated write data, plus load lane
// extraction with optional sign extension.
module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [1:0]  a_i,
    input  logic [1:0]  mask_i,
    input  logic        rsign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {a_i, 3'b000};

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        load_o  = rdata_i;
        case (mask_i)
            MASK_B: begin
                wstrb_o = 4'b0001 << a_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = rsign_i ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
            end
            MASK_H: begin
                wstrb_o = 4'b0011 << {a_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                load_o  = rsign_i ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
            end
            MASK_W: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                load_o  = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Memory-access / write-back stage: one bus transaction per load/store, then a
// single-cycle retirement pulse. Define YSYX_25040111_MISALIGN_CHK_EN to trap
// misaligned half/word accesses without touching the bus.
module ysyx_25040111_lsu
    import ysyx_25040111_lsu_pkg::*;
#(
    parameter int         BUS_DW   = 32,
    parameter logic [3:0] LD_FAULT = ERR_LD_FAULT,
    parameter logic [3:0] ST_FAULT = ERR_ST_FAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_men,
    input  logic              in_write,
    input  logic [BUS_DW-1:0] in_addr,
    input  logic [BUS_DW-1:0] in_wdata,
    input  logic [1:0]        in_mask,
    input  logic              in_rsign,
    input  logic [4:0]        in_ard,
    input  logic [BUS_DW-1:0] in_rd,
    input  logic              in_gen,
    input  logic [11:0]       in_acsr,
    input  logic [BUS_DW-1:0] in_csr,
    input  logic              in_sen,
    input  logic [BUS_DW-1:0] in_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [BUS_DW-1:0] mem_addr,
    output logic              mem_wen,
    output logic [BUS_DW-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    input  logic [BUS_DW-1:0] mem_rdata,
    input  logic              mem_resp_err,
    output logic              gpr_wen,
    output logic [4:0]        gpr_waddr,
    output logic [BUS_DW-1:0] gpr_wdata,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [BUS_DW-1:0] csr_wdata,
    output logic              finish,
    output logic [4:0]        frd,
    output logic [BUS_DW-1:0] wb_pc,
    output logic              err,
    output logic [3:0]        errtp
);

    lsu_state_e        state_q;
    logic              write_q, rsign_q, gen_q, sen_q;
    logic [1:0]        mask_q, addr_lo_q;
    logic [4:0]        ard_q;
    logic [11:0]       acsr_q;
    logic [BUS_DW-1:0] rd_q, csr_q, pc_q;

    logic              mem_req_valid_q, mem_wen_q;
    logic [BUS_DW-1:0] mem_addr_q, mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic              gpr_wen_q, gpr_wen_d, csr_wen_q, csr_wen_d;
    logic              finish_q, finish_d, err_q, err_d;
    logic [4:0]        gpr_waddr_q, gpr_waddr_d, frd_q, frd_d;
    logic [11:0]       csr_waddr_q, csr_waddr_d;
    logic [3:0]        errtp_q, errtp_d;
    logic [BUS_DW-1:0] gpr_wdata_q, gpr_wdata_d, csr_wdata_q, csr_wdata_d;
    logic [BUS_DW-1:0] wb_pc_q, wb_pc_d;

    logic              accept, is_mem, misalign;
    logic [1:0]        align_a, align_mask;
    logic [3:0]        align_wstrb;
    logic [BUS_DW-1:0] align_wdata, align_load;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = in_men & (in_mask != 2'b00);
`ifdef YSYX_25040111_MISALIGN_CHK_EN
    assign misalign = is_mem & is_misaligned(in_mask, in_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Store lanes are computed from live inputs at handshake; load lanes from latched fields.
    assign align_a    = (state_q == ST_IDLE) ? in_addr[1:0] : addr_lo_q;
    assign align_mask = (state_q == ST_IDLE) ? in_mask      : mask_q;

    ysyx_25040111_lsu_align u_align (
        .a_i     (align_a),
        .mask_i  (align_mask),
        .rsign_i (rsign_q),
        .wdata_i (in_wdata),
        .rdata_i (mem_rdata),
        .wstrb_o (align_wstrb),
        .wdata_o (align_wdata),
        .load_o  (align_load)
    );

    always_comb begin
        finish_d    = 1'b0;
        frd_d       = 5'd0;
        wb_pc_d     = '0;
        gpr_wen_d   = 1'b0;
        gpr_waddr_d = 5'd0;
        gpr_wdata_d = '0;
        csr_wen_d   = 1'b0;
        csr_waddr_d = 12'd0;
        csr_wdata_d = '0;
        err_d       = 1'b0;
        errtp_d     = 4'd0;
        if (accept && (!is_mem || misalign)) begin
            finish_d    = 1'b1;
            frd_d       = in_ard;
            wb_pc_d     = in_pc;
            gpr_wen_d   = in_gen & ~misalign;
            gpr_waddr_d = in_ard;
            gpr_wdata_d = in_rd;
            csr_wen_d   = in_sen;
            csr_waddr_d = in_acsr;
            csr_wdata_d = in_csr;
            err_d       = misalign;
            errtp_d     = misalign ? (in_write ? ERR_ST_MISALIGN : ERR_LD_MISALIGN) : 4'd0;
        end else if (state_q == ST_RESP && mem_resp_valid) begin
            finish_d    = 1'b1;
            frd_d       = ard_q;
            wb_pc_d     = pc_q;
            gpr_wen_d   = gen_q & ~mem_resp_err;
            gpr_waddr_d = ard_q;
            gpr_wdata_d = write_q ? rd_q : align_load;
            csr_wen_d   = sen_q;
            csr_waddr_d = acsr_q;
            csr_wdata_d = csr_q;
            err_d       = mem_resp_err;
            errtp_d     = mem_resp_err ? (write_q ? ST_FAULT : LD_FAULT) : 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            write_q         <= 1'b0;
            rsign_q         <= 1'b0;
            gen_q           <= 1'b0;
            sen_q           <= 1'b0;
            mask_q          <= 2'b00;
            addr_lo_q       <= 2'b00;
            ard_q           <= 5'd0;
            acsr_q          <= 12'd0;
            rd_q            <= '0;
            csr_q           <= '0;
            pc_q            <= '0;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= 4'b0000;
            finish_q        <= 1'b0;
            frd_q           <= 5'd0;
            wb_pc_q         <= '0;
            gpr_wen_q       <= 1'b0;
            gpr_waddr_q     <= 5'd0;
            gpr_wdata_q     <= '0;
            csr_wen_q       <= 1'b0;
            csr_waddr_q     <= 12'd0;
            csr_wdata_q     <= '0;
            err_q           <= 1'b0;
            errtp_q         <= 4'd0;
        end else begin
            finish_q    <= finish_d;
            frd_q       <= frd_d;
            wb_pc_q     <= wb_pc_d;
            gpr_wen_q   <= gpr_wen_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wdata_q <= gpr_wdata_d;
            csr_wen_q   <= csr_wen_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            err_q       <= err_d;
            errtp_q     <= errtp_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q   <= in_write;
                        rsign_q   <= in_rsign;
                        gen_q     <= in_gen;
                        sen_q     <= in_sen;
                        mask_q    <= in_mask;
                        addr_lo_q <= in_addr[1:0];
                        ard_q     <= in_ard;
                        acsr_q    <= in_acsr;
                        rd_q      <= in_rd;
                        csr_q     <= in_csr;
                        pc_q      <= in_pc;
                        if (is_mem && !misalign) begin
                            state_q         <= ST_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= {in_addr[BUS_DW-1:2], 2'b00};
                            mem_wen_q       <= in_write;
                            mem_wdata_q     <= in_write ? align_wdata : '0;
                            mem_wstrb_q     <= in_write ? align_wstrb : 4'b0000;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        state_q <= ST_WB;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign gpr_wen       = gpr_wen_q;
    assign gpr_waddr     = gpr_waddr_q;
    assign gpr_wdata     = gpr_wdata_q;
    assign csr_wen       = csr_wen_q;
    assign csr_waddr     = csr_waddr_q;
    assign csr_wdata     = csr_wdata_q;
    assign finish        = finish_q;
    assign frd           = frd_q;
    assign wb_pc         = wb_pc_q;
    assign err           = err_q;
    assign errtp         = errtp_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed bench for ysyx_25040111_lsu; inputs change and outputs are sampled
// on the falling edge. Honours YSYX_25040111_MISALIGN_CHK_EN if defined.
module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_men, in_write, in_rsign, in_gen, in_sen;
    logic [31:0] in_addr, in_wdata, in_rd, in_csr, in_pc;
    logic [1:0]  in_mask;
    logic [4:0]  in_ard;
    logic [11:0] in_acsr;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        gpr_wen, csr_wen, finish, err;
    logic [4:0]  gpr_waddr, frd;
    logic [31:0] gpr_wdata, csr_wdata, wb_pc;
    logic [11:0] csr_waddr;
    logic [3:0]  errtp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_men(in_men), .in_write(in_write),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_mask(in_mask), .in_rsign(in_rsign),
        .in_ard(in_ard), .in_rd(in_rd), .in_gen(in_gen), .in_acsr(in_acsr),
        .in_csr(in_csr), .in_sen(in_sen), .in_pc(in_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .finish(finish), .frd(frd), .wb_pc(wb_pc), .err(err), .errtp(errtp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Drive one instruction for a single cycle; returns at the falling edge after the handshake.
    task automatic issue(input logic men, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] mask, input logic rs,
                         input logic [4:0] ard, input logic [31:0] rd, input logic gen);
        in_men = men; in_write = wr; in_addr = addr; in_wdata = wd; in_mask = mask;
        in_rsign = rs; in_ard = ard; in_rd = rd; in_gen = gen; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic accept_req();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic rerr);
        mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = rerr;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_men = 1'b0; in_write = 1'b0; in_addr = 32'h0;
        in_wdata = 32'h0; in_mask = 2'b00; in_rsign = 1'b0; in_ard = 5'd0; in_rd = 32'h0;
        in_gen = 1'b0; in_acsr = 12'h0; in_csr = 32'h0; in_sen = 1'b0; in_pc = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_finish", {31'h0, finish}, 32'd0);
        chk("rst_req_valid", {31'h0, mem_req_valid}, 32'd0);
        chk("rst_gpr_wen", {31'h0, gpr_wen}, 32'd0);

        // Non-memory ALU op with a CSR write riding along
        in_pc = 32'h8000_0100; in_sen = 1'b1; in_acsr = 12'h341; in_csr = 32'h0000_DEAD;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd5, 32'h1234, 1'b1);
        in_sen = 1'b0;
        $display("txn: alu rd=5 data=%h", gpr_wdata);
        chk("alu_in_ready", {31'h0, in_ready}, 32'd0);
        chk("alu_gpr_wen", {31'h0, gpr_wen}, 32'd1);
        chk("alu_waddr", {27'h0, gpr_waddr}, 32'd5);
        chk("alu_wdata", gpr_wdata, 32'h1234);
        chk("alu_finish", {31'h0, finish}, 32'd1);
        chk("alu_frd", {27'h0, frd}, 32'd5);
        chk("alu_wb_pc", wb_pc, 32'h8000_0100);
        chk("alu_csr_wen", {31'h0, csr_wen}, 32'd1);
        chk("alu_csr_waddr", {20'h0, csr_waddr}, 32'h341);
        chk("alu_csr_wdata", csr_wdata, 32'h0000_DEAD);
        tick();
        chk("alu_after_ready", {31'h0, in_ready}, 32'd1);
        chk("alu_after_finish", {31'h0, finish}, 32'd0);
        chk("alu_after_csr_wen", {31'h0, csr_wen}, 32'd0);

        // sb to byte lane 3 with a stalled bus
        issue(1'b1, 1'b1, 32'h8000_0003, 32'h0000_00AB, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("sb_fin_early", {31'h0, finish}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("sb_req_valid", {31'h0, mem_req_valid}, 32'd1);
            chk("sb_addr", mem_addr, 32'h8000_0000);
            chk("sb_wstrb", {28'h0, mem_wstrb}, 32'b1000);
            chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
            chk("sb_wen", {31'h0, mem_wen}, 32'd1);
            tick();
        end
        accept_req();
        chk("sb_req_dropped", {31'h0, mem_req_valid}, 32'd0);
        respond(32'h0, 1'b0);
        $display("txn: sb addr=%h strb=%b", mem_addr, mem_wstrb);
        chk("sb_finish", {31'h0, finish}, 32'd1);
        chk("sb_gpr_wen", {31'h0, gpr_wen}, 32'd0);
        chk("sb_err", {31'h0, err}, 32'd0);
        tick();

        // sh to upper half, sw aligned
        issue(1'b1, 1'b1, 32'h8000_0006, 32'h0000_BEEF, 2'b10, 1'b0, 5'd0, 32'h0, 1'b0);
        $display("txn: sh addr=%h strb=%b", mem_addr, mem_wstrb);
        chk("sh_addr", mem_addr, 32'h8000_0004);
        chk("sh_wstrb", {28'h0, mem_wstrb}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        accept_req(); respond(32'h0, 1'b0); tick();
        issue(1'b1, 1'b1, 32'h8000_0008, 32'h1122_3344, 2'b11, 1'b0, 5'd0, 32'h0, 1'b0);
        $display("txn: sw addr=%h strb=%b", mem_addr, mem_wstrb);
        chk("sw_wstrb", {28'h0, mem_wstrb}, 32'b1111);
        chk("sw_wdata", mem_wdata, 32'h1122_3344);
        accept_req(); respond(32'h0, 1'b0); tick();

        // lh upper half, signed then unsigned
        issue(1'b1, 1'b0, 32'h8000_0102, 32'h0, 2'b10, 1'b1, 5'd7, 32'h0, 1'b1);
        chk("lhs_wen_bus", {31'h0, mem_wen}, 32'd0);
        chk("lhs_wstrb", {28'h0, mem_wstrb}, 32'd0);
        chk("lhs_addr", mem_addr, 32'h8000_0100);
        accept_req(); respond(32'h8001_0000, 1'b0);
        $display("txn: lh signed data=%h", gpr_wdata);
        chk("lhs_gpr_wen", {31'h0, gpr_wen}, 32'd1);
        chk("lhs_waddr", {27'h0, gpr_waddr}, 32'd7);
        chk("lhs_wdata", gpr_wdata, 32'hFFFF_8001);
        tick();
        issue(1'b1, 1'b0, 32'h8000_0102, 32'h0, 2'b10, 1'b0, 5'd7, 32'h0, 1'b1);
        accept_req(); respond(32'h8001_0000, 1'b0);
        $display("txn: lh unsigned data=%h", gpr_wdata);
        chk("lhu_wdata", gpr_wdata, 32'h0000_8001);
        tick();

        // lb from lane 1, signed
        issue(1'b1, 1'b0, 32'h8000_0201, 32'h0, 2'b01, 1'b1, 5'd9, 32'h0, 1'b1);
        accept_req(); respond(32'h0000_F000, 1'b0);
        $display("txn: lb signed data=%h", gpr_wdata);
        chk("lb_wdata", gpr_wdata, 32'hFFFF_FFF0);
        tick();

        // Load access fault
        issue(1'b1, 1'b0, 32'h8000_0010, 32'h0, 2'b11, 1'b0, 5'd3, 32'h0, 1'b1);
        accept_req(); respond(32'h1234_5678, 1'b1);
        $display("txn: lw fault err=%b errtp=%0d", err, errtp);
        chk("ldf_gpr_wen", {31'h0, gpr_wen}, 32'd0);
        chk("ldf_err", {31'h0, err}, 32'd1);
        chk("ldf_errtp", {28'h0, errtp}, 32'd5);
        chk("ldf_finish", {31'h0, finish}, 32'd1);
        tick();
        chk("ldf_err_clear", {31'h0, err}, 32'd0);

        // Reset while waiting for a response; the late response must be ignored
        issue(1'b1, 1'b0, 32'h8000_0020, 32'h0, 2'b11, 1'b0, 5'd4, 32'h0, 1'b1);
        accept_req();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("txn: reset in RESP ready=%b", in_ready);
        chk("rsr_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rsr_req_valid", {31'h0, mem_req_valid}, 32'd0);
        chk("rsr_finish", {31'h0, finish}, 32'd0);
        respond(32'hCAFE_F00D, 1'b0);
        chk("rsr_late_finish", {31'h0, finish}, 32'd0);
        chk("rsr_late_gpr_wen", {31'h0, gpr_wen}, 32'd0);
        tick();
        chk("rsr_late_ready", {31'h0, in_ready}, 32'd1);

        // Misaligned word load
        issue(1'b1, 1'b0, 32'h8000_0031, 32'h0, 2'b11, 1'b0, 5'd6, 32'h0, 1'b1);
`ifdef YSYX_25040111_MISALIGN_CHK_EN
        $display("txn: lw misaligned trapped errtp=%0d", errtp);
        chk("mis_req_valid", {31'h0, mem_req_valid}, 32'd0);
        chk("mis_err", {31'h0, err}, 32'd1);
        chk("mis_errtp", {28'h0, errtp}, 32'd4);
        chk("mis_gpr_wen", {31'h0, gpr_wen}, 32'd0);
        chk("mis_finish", {31'h0, finish}, 32'd1);
        tick();
`else
        $display("txn: lw misaligned on bus addr=%h", mem_addr);
        chk("mis_req_valid", {31'h0, mem_req_valid}, 32'd1);
        chk("mis_addr", mem_addr, 32'h8000_0030);
        accept_req(); respond(32'h0BAD_F00D, 1'b0);
        chk("mis_err", {31'h0, err}, 32'd0);
        chk("mis_wdata", gpr_wdata, 32'h0BAD_F00D);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
